// File: rtl/bit_sync_tx_pkg.sv
// bit_sync_tx_pkg: shared state encoding and default parameters for the source-side REQ/ACK sender.
package bit_sync_tx_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1023;
endpackage

// File: rtl/bit_sync_tx_ack_sync.sv
// ack_level_sync: multi-stage level synchronizer bringing the destination ACK into the source clock.
module ack_level_sync
    import bit_sync_tx_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;
    always_ff @(posedge clk) begin
        sr <= rst ? '0 : {sr[STAGES-2:0], d};
    end
    assign q = sr[STAGES-1];
endmodule

// File: rtl/bit_sync_tx.sv
// bit_sync_tx: turns a source-domain pulse plus payload into a 4-phase REQ/ACK handshake,
// with a one-entry pending buffer, a REQ timeout and sticky overflow/timeout flags.
module bit_sync_tx
    import bit_sync_tx_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  Source_CLK,
    input  logic                  RST,
    input  logic                  PULSE_IN,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  ACK_ASYNC,
    output logic                  REQ_OUT,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVERFLOW,
    output logic                  TIMEOUT
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                state, state_n;
    logic [TW-1:0]         timer, timer_n;
    logic                  pend, pend_n, ack_s, launch, finish;
    logic                  req_n, done_n, ovf_n, to_n;
    logic [DATA_WIDTH-1:0] pend_data, pend_data_n, data_n, launch_data;

    ack_level_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk(Source_CLK),
        .rst(RST),
        .d  (ACK_ASYNC),
        .q  (ack_s)
    );

    always_ff @(posedge Source_CLK) begin
        if (RST) begin
            state     <= IDLE;
            timer     <= '0;
            pend      <= 1'b0;
            pend_data <= '0;
            REQ_OUT   <= 1'b0;
            DATA_OUT  <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            OVERFLOW  <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            pend      <= pend_n;
            pend_data <= pend_data_n;
            REQ_OUT   <= req_n;
            DATA_OUT  <= data_n;
            BUSY      <= state_n != IDLE;
            DONE      <= done_n;
            OVERFLOW  <= ovf_n;
            TIMEOUT   <= to_n;
        end
    end

    assign finish = state == WAIT_LOW && !ack_s;

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        pend_n      = pend;
        pend_data_n = pend_data;
        req_n       = REQ_OUT;
        data_n      = DATA_OUT;
        done_n      = 1'b0;
        ovf_n       = OVERFLOW;
        to_n        = TIMEOUT;
        launch      = 1'b0;
        launch_data = DATA_IN;
        case (state)
            IDLE: launch = PULSE_IN;
            REQ: begin
                if (ack_s || timer == LAST) begin
                    req_n   = 1'b0;
                    to_n    = TIMEOUT | ~ack_s;
                    state_n = WAIT_LOW;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            WAIT_LOW: begin
                if (!ack_s) begin
                    done_n      = 1'b1;
                    state_n     = IDLE;
                    launch      = pend | PULSE_IN;
                    launch_data = pend ? pend_data : DATA_IN;
                    pend_n      = pend & PULSE_IN;
                    pend_data_n = (pend & PULSE_IN) ? DATA_IN : pend_data;
                end
            end
            default: state_n = IDLE;
        endcase
        // a pulse not consumed by a launch or a completion goes to the pending slot
        if (PULSE_IN && state != IDLE && !finish) begin
            pend_n      = 1'b1;
            pend_data_n = pend ? pend_data : DATA_IN;
            ovf_n       = OVERFLOW | pend;
        end
        if (launch) begin
            state_n = REQ;
            req_n   = 1'b1;
            data_n  = launch_data;
            timer_n = '0;
        end
    end
endmodule

// File: tb/tb_bit_sync_tx.sv
// tb_bit_sync_tx: scoreboard bench; a destination responder drives ACK, an occupancy model predicts delivery.
module tb_bit_sync_tx;
    localparam int DW = 8;
    localparam int SS = 2;
    localparam int TO = 15;

    logic          Source_CLK = 1'b0;
    logic          RST = 1'b1;
    logic          PULSE_IN = 1'b0;
    logic [DW-1:0] DATA_IN = '0;
    logic          ACK_ASYNC = 1'b0;
    logic          REQ_OUT, BUSY, DONE, OVERFLOW, TIMEOUT;
    logic [DW-1:0] DATA_OUT;

    bit_sync_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
        .Source_CLK(Source_CLK),
        .RST       (RST),
        .PULSE_IN  (PULSE_IN),
        .DATA_IN   (DATA_IN),
        .ACK_ASYNC (ACK_ASYNC),
        .REQ_OUT   (REQ_OUT),
        .DATA_OUT  (DATA_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .OVERFLOW  (OVERFLOW),
        .TIMEOUT   (TIMEOUT)
    );

    always #5 Source_CLK = ~Source_CLK;

    int cyc = 0;
    always @(posedge Source_CLK) cyc <= cyc + 1;

    int            total = 0, passed = 0;
    logic [DW-1:0] exp_q[$];
    int            done_q[$], comp_q[$];
    int            n_acc = 0, n_comp = 0;
    bit            exp_ovf = 0, exp_to = 0, mon_on = 0, resp_on = 0, rnd_dly = 0, prev_req = 0;
    logic [DW-1:0] held = '0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic tick();
        @(posedge Source_CLK);
        #1;
    endtask

    // Issue one pulse; a word is accepted while fewer than two words are outstanding,
    // counting completions that happen on the same edge as freeing a slot.
    task automatic pulse(input logic [DW-1:0] d);
        PULSE_IN = 1'b1;
        DATA_IN  = d;
        tick();
        PULSE_IN = 1'b0;
        while (comp_q.size() > 0 && comp_q[0] <= cyc) begin
            void'(comp_q.pop_front());
            n_comp++;
        end
        if (n_acc - n_comp < 2) begin
            exp_q.push_back(d);
            n_acc++;
        end else exp_ovf = 1'b1;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && done_q.size() == 0 && !REQ_OUT && !BUSY) break;
            tick();
        end
        chk("drain_in_time", int'(i < 300), 1);
    endtask

    task automatic wait_comp(output int target);
        for (int i = 0; i < 50 && comp_q.size() == 0; i++) tick();
        chk("completion_seen", int'(comp_q.size() > 0), 1);
        target = comp_q.size() > 0 ? comp_q[0] : cyc;
    endtask

    // destination side: follow REQ with ACK after a delay; completion is seen SS+1 edges after ACK drops
    initial begin : responder
        int cnt = 0;
        int dly = 3;
        forever begin
            tick();
            if (resp_on && ACK_ASYNC != REQ_OUT) begin
                if (cnt >= dly) begin
                    ACK_ASYNC = REQ_OUT;
                    cnt = 0;
                    dly = rnd_dly ? int'($urandom_range(0, 3)) : 3;
                    if (!REQ_OUT) begin
                        done_q.push_back(cyc + SS + 1);
                        comp_q.push_back(cyc + SS + 1);
                    end
                end else cnt++;
            end else cnt = 0;
        end
    end

    always @(negedge Source_CLK) begin
        if (mon_on) begin
            if (REQ_OUT && !prev_req) begin
                if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
                else chk("req_data", int'(DATA_OUT), int'(exp_q.pop_front()));
                held = DATA_OUT;
            end else if (REQ_OUT) chk("data_hold", int'(DATA_OUT), int'(held));
            if (DONE) begin
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
            chk("overflow_flag", int'(OVERFLOW), int'(exp_ovf));
            chk("timeout_flag", int'(TIMEOUT), int'(exp_to));
        end
        prev_req = REQ_OUT;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : main
        int target, p;
        repeat (3) tick();
        chk("rst_req", int'(REQ_OUT), 0);
        chk("rst_data", int'(DATA_OUT), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_ovf", int'(OVERFLOW), 0);
        chk("rst_to", int'(TIMEOUT), 0);
        RST = 1'b0;
        mon_on = 1;
        resp_on = 1;

        pulse(8'hA5);
        chk("single_busy", int'(BUSY), 1);
        chk("single_req", int'(REQ_OUT), 1);
        drain();
        chk("single_idle", int'(BUSY), 0);

        pulse(8'h11);
        pulse(8'h22);
        wait_comp(target);
        while (cyc < target) tick();
        chk("b2b_done", int'(DONE), 1);
        chk("b2b_rerise", int'(REQ_OUT), 1);
        chk("b2b_data", int'(DATA_OUT), 8'h22);
        drain();

        pulse(8'h44);
        pulse(8'h55);
        wait_comp(target);
        while (cyc < target - 1) tick();
        pulse(8'h66);
        chk("simul_ovf", int'(OVERFLOW), 0);
        drain();

        pulse(8'h01);
        pulse(8'h02);
        pulse(8'h03);
        chk("ovf_set", int'(OVERFLOW), 1);
        drain();
        chk("ovf_sticky", int'(OVERFLOW), 1);

        rnd_dly = 1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) pulse(DW'($urandom_range(0, 255)));
            else tick();
        end
        drain();
        rnd_dly = 0;

        resp_on = 0;
        pulse(8'h7E);
        p = cyc;
        done_q.push_back(p + TO + 1);
        comp_q.push_back(p + TO + 1);
        while (cyc < p + TO - 1) tick();
        chk("to_req_held", int'(REQ_OUT), 1);
        chk("to_flag_clear", int'(TIMEOUT), 0);
        tick();
        exp_to = 1;
        chk("to_req_drop", int'(REQ_OUT), 0);
        chk("to_flag_set", int'(TIMEOUT), 1);
        tick();
        chk("to_done", int'(DONE), 1);
        tick();
        chk("to_idle", int'(BUSY), 0);

        pulse(8'h5A);
        pulse(8'hC3);
        tick();
        RST = 1'b1;
        mon_on = 0;
        tick();
        chk("mid_rst_req", int'(REQ_OUT), 0);
        chk("mid_rst_data", int'(DATA_OUT), 0);
        chk("mid_rst_busy", int'(BUSY), 0);
        chk("mid_rst_done", int'(DONE), 0);
        chk("mid_rst_ovf", int'(OVERFLOW), 0);
        chk("mid_rst_to", int'(TIMEOUT), 0);
        exp_q.delete();
        done_q.delete();
        comp_q.delete();
        n_acc = 0;
        n_comp = 0;
        exp_ovf = 0;
        exp_to = 0;
        RST = 1'b0;
        mon_on = 1;
        repeat (20) tick();
        chk("post_rst_req", int'(REQ_OUT), 0);
        chk("post_rst_busy", int'(BUSY), 0);

        resp_on = 1;
        pulse(8'h3C);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bit_sync_tx.md
# bit_sync_tx

Source-side companion of the destination pulse synchronizer: turns a one-cycle request pulse plus data word in the Source_CLK domain into a stable 4-phase REQ/ACK level handshake that the destination domain samples through its 2-FF synchronizer. DATA_OUT is held constant while REQ_OUT is high, so the destination may capture it on its synchronized pulse. Sits at the source end of every APB-side clock-domain crossing that carries a strobe with payload.

## Interface
- DATA_WIDTH, 8, width of payload carried with each request
- SYNC_STAGES, 2, flip-flop stages synchronizing ACK_ASYNC into Source_CLK (>=2)
- TIMEOUT_CYCLES, 1023, max Source_CLK cycles REQ_OUT may wait for ACK before abort (>=1)
- Source_CLK  input  1  source-domain clock; single clock for the whole block
- RST  input  1  synchronous, active-high reset
- PULSE_IN  input  1  one-cycle transfer request (Source_CLK domain)
- DATA_IN  input  DATA_WIDTH  payload, sampled in the cycle PULSE_IN=1
- ACK_ASYNC  input  1  acknowledge level from destination domain (asynchronous)
- REQ_OUT  output  1  registered request level to destination
- DATA_OUT  output  DATA_WIDTH  registered payload, stable whenever REQ_OUT=1
- BUSY  output  1  handshake in progress (state != IDLE)
- DONE  output  1  one-cycle pulse: handshake completed (ACK seen low again)
- OVERFLOW  output  1  sticky: a PULSE_IN was dropped; cleared only by RST
- TIMEOUT  output  1  sticky: a handshake was aborted on timeout; cleared only by RST

## Operation
- ack_s = ACK_ASYNC after SYNC_STAGES flops; only ack_s is used by logic.
- FSM states: IDLE, REQ, WAIT_LOW.
- IDLE: PULSE_IN=1 -> DATA_OUT<=DATA_IN, REQ_OUT<=1, -> REQ.
- REQ: ack_s=1 -> REQ_OUT<=0, -> WAIT_LOW. Timer reaches TIMEOUT_CYCLES with ack_s=0 -> REQ_OUT<=0, TIMEOUT<=1, -> WAIT_LOW.
- WAIT_LOW: ack_s=0 -> DONE=1 for one cycle; if pending valid: DATA_OUT<=pending, REQ_OUT<=1, -> REQ; else if PULSE_IN=1: launch DATA_IN the same way; else -> IDLE.
- One-entry pending buffer: PULSE_IN while state != IDLE and pending empty -> capture DATA_IN. Pending full and not freed this cycle -> drop, OVERFLOW<=1.
- Simultaneous: completion launching pending + PULSE_IN same cycle -> new pulse enters the freed pending slot (no overflow).
- Timer: clears on entry to REQ, increments each REQ cycle; width $clog2(TIMEOUT_CYCLES+1); never wraps.
- DATA_OUT changes only on the edge that raises REQ_OUT.

## Timing
- Reset values: REQ_OUT=0, DATA_OUT=0, BUSY=0, DONE=0, OVERFLOW=0, TIMEOUT=0; state IDLE, pending empty, sync flops 0, timer 0.
- RST mid-handshake: all of the above on the next edge; pending data discarded; REQ_OUT drops regardless of ack.
- PULSE_IN at edge n (IDLE) -> REQ_OUT=1, BUSY=1 after edge n+1.
- ACK_ASYNC rise -> ack_s=1 after SYNC_STAGES edges -> REQ_OUT=0 on following edge.
- ACK_ASYNC fall -> ack_s=0 after SYNC_STAGES edges -> DONE on following edge; back-to-back REQ_OUT re-rises on that same edge.
- Minimum gap between REQ_OUT falling and re-rising: SYNC_STAGES+1 cycles.
- Outputs all registered; no combinational input-to-output path.

## Structure
- Shared package: state enum (IDLE, REQ, WAIT_LOW) and default constants for DATA_WIDTH, SYNC_STAGES, TIMEOUT_CYCLES.
- One sub-module: ack_level_sync (SYNC_STAGES-deep level synchronizer, sync active-high reset, no pulse conversion).
- FSM, timer, pending buffer, sticky flags in top level.

## Test plan
- Single transfer: PULSE_IN with DATA_IN=0xA5, ACK rises 3 cycles after REQ, falls 3 after REQ drop -> REQ high, DATA_OUT=0xA5 stable throughout, one DONE, BUSY back to 0.
- Back-to-back: pulses 0x11 then 0x22 one cycle apart -> two handshakes in order, DATA_OUT 0x11 then 0x22, REQ re-rises on DONE edge, OVERFLOW=0.
- Overflow: three pulses (0x01,0x02,0x03) during one handshake -> 0x01, 0x02 delivered, 0x03 dropped, OVERFLOW=1 sticky.
- Timeout: TIMEOUT_CYCLES=15, ACK held 0 -> REQ_OUT falls after 15 REQ cycles, TIMEOUT=1, DONE one cycle later.
- Reset mid-REQ: RST asserted while REQ_OUT=1 and pending full -> next edge all outputs 0, pending cleared; no DONE after reset release.
- Simultaneous completion + pulse with pending full -> no overflow, both remaining words delivered in order.
